// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcodes, FSM encoding, port id.
package alu_arbiter_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_MUL   = 4'b0101;
    localparam logic [3:0] OP_DIV   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1000;
    localparam logic [3:0] OP_MOD   = 4'b1001;
    localparam logic [3:0] OP_LOADI = 4'b1010;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    typedef logic port_id_t;

endpackage

// File: rtl/alu16.sv
// Combinational 16-bit ALU; divide/modulo by zero and illegal opcodes give 0 with err set.
module alu16
    import alu_arbiter_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        err
);

    logic        div_zero;
    logic [15:0] divisor;

    assign div_zero = (b == 16'h0000);
    // Keep the divider away from a zero divisor so its output is never X.
    assign divisor  = div_zero ? 16'h0001 : b;

    always_comb begin
        result = 16'h0000;
        err    = 1'b0;
        case (op)
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_MUL:   result = a * b;
            OP_NOT:   result = ~a;
            OP_LOADI: result = a;
            OP_DIV: begin
                if (div_zero) err = 1'b1;
                else          result = a / divisor;
            end
            OP_MOD: begin
                if (div_zero) err = 1'b1;
                else          result = a % divisor;
            end
            default:  err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; IDLE -> EXEC -> RESP,
// response held until the owner's rsp_ready, and no new grant until back in IDLE.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [15:0] rsp0_result,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp1_result,
    output logic        rsp1_err,
    output logic        busy
);

    logic [1:0]  state;
    port_id_t    ptr;
    port_id_t    owner;
    logic [3:0]  lat_op;
    logic [15:0] lat_a;
    logic [15:0] lat_b;
    logic [15:0] res_q;
    logic        err_q;

    logic        alu_result_unused_guard;
    logic [15:0] alu_result;
    logic        alu_err;

    logic        any_req;
    port_id_t    grant_id;
    logic        grant;
    logic        owner_rdy;

    assign any_req  = req0_valid | req1_valid;
    // Pointer only decides ties; a lone requester wins regardless.
    assign grant_id = (req0_valid && req1_valid) ? ptr : port_id_t'(req1_valid);
    assign grant    = (state == ST_IDLE) && any_req;

    assign req0_ready = grant && (grant_id == 1'b0);
    assign req1_ready = grant && (grant_id == 1'b1);

    assign owner_rdy = (owner == 1'b0) ? rsp0_ready : rsp1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ptr    <= 1'b0;
            owner  <= 1'b0;
            lat_op <= 4'h0;
            lat_a  <= 16'h0000;
            lat_b  <= 16'h0000;
            res_q  <= 16'h0000;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner  <= grant_id;
                        ptr    <= ~grant_id;
                        lat_op <= grant_id ? req1_op : req0_op;
                        lat_a  <= grant_id ? req1_a  : req0_a;
                        lat_b  <= grant_id ? req1_b  : req0_b;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_q <= alu_result;
                    err_q <= alu_err;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (owner_rdy) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    alu16 u_alu (
        .op     (lat_op),
        .a      (lat_a),
        .b      (lat_b),
        .result (alu_result),
        .err    (alu_err)
    );

    assign alu_result_unused_guard = 1'b0;

    assign rsp0_valid  = (state == ST_RESP) && (owner == 1'b0);
    assign rsp1_valid  = (state == ST_RESP) && (owner == 1'b1);
    assign rsp0_result = (owner == 1'b0) ? res_q : 16'h0000;
    assign rsp1_result = (owner == 1'b1) ? res_q : 16'h0000;
    assign rsp0_err    = rsp0_valid & err_q;
    assign rsp1_err    = rsp1_valid & err_q;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: arbitration, latency, ALU results, backpressure, reset.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [15:0] rsp0_result, rsp1_result;
    logic        rsp0_err, rsp1_err, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_op = 4'h0; req1_op = 4'h0;
        req0_a = 16'h0; req0_b = 16'h0; req1_a = 16'h0; req1_b = 16'h0;
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req0_ready"}, {15'b0, req0_ready}, 16'h0);
        chk({tag, "_req1_ready"}, {15'b0, req1_ready}, 16'h0);
        chk({tag, "_rsp0_valid"}, {15'b0, rsp0_valid}, 16'h0);
        chk({tag, "_rsp1_valid"}, {15'b0, rsp1_valid}, 16'h0);
        chk({tag, "_rsp0_result"}, rsp0_result, 16'h0);
        chk({tag, "_rsp1_result"}, rsp1_result, 16'h0);
        chk({tag, "_rsp0_err"}, {15'b0, rsp0_err}, 16'h0);
        chk({tag, "_rsp1_err"}, {15'b0, rsp1_err}, 16'h0);
        chk({tag, "_busy"}, {15'b0, busy}, 16'h0);
    endtask

    // One lone-requester transaction, called aligned just after a negedge in IDLE.
    task automatic do_op(input string tag, input logic port, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_res, input logic exp_err);
        if (port == 1'b0) begin
            req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        chk({tag, "_grant"}, {14'b0, req1_ready, req0_ready}, port ? 16'h2 : 16'h1);
        @(negedge clk);
        // Scramble inputs after acceptance; result must not change.
        req0_valid = 0; req1_valid = 0;
        req0_op = 4'h2; req1_op = 4'h2;
        req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
        #1;
        chk({tag, "_exec_busy"}, {15'b0, busy}, 16'h1);
        chk({tag, "_exec_noval"}, {14'b0, rsp1_valid, rsp0_valid}, 16'h0);
        @(negedge clk);
        #1;
        chk({tag, "_valid"}, {14'b0, rsp1_valid, rsp0_valid}, port ? 16'h2 : 16'h1);
        chk({tag, "_result"}, port ? rsp1_result : rsp0_result, exp_res);
        chk({tag, "_err"}, {15'b0, port ? rsp1_err : rsp0_err}, {15'b0, exp_err});
        if (port == 1'b0) rsp0_ready = 1; else rsp1_ready = 1;
        @(negedge clk);
        #1;
        chk({tag, "_idle"}, {13'b0, busy, rsp1_valid, rsp0_valid}, 16'h0);
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst_n = 0;
        @(negedge clk); @(negedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1;
        @(negedge clk);

        // Contention from reset: grants alternate 0,1,0,1 starting with port 0.
        req0_valid = 1; req0_op = 4'b0000; req0_a = 16'h0001; req0_b = 16'h0002;
        req1_valid = 1; req1_op = 4'b0001; req1_a = 16'h0000; req1_b = 16'h0001;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d_grant", k), {14'b0, req1_ready, req0_ready},
                (k % 2) ? 16'h2 : 16'h1);
            @(negedge clk);
            @(negedge clk);
            #1;
            chk($sformatf("rr%0d_valid", k), {14'b0, rsp1_valid, rsp0_valid},
                (k % 2) ? 16'h2 : 16'h1);
            chk($sformatf("rr%0d_result", k), (k % 2) ? rsp1_result : rsp0_result,
                (k % 2) ? 16'hFFFF : 16'h0003);
            @(negedge clk);
        end
        clear_inputs();
        @(negedge clk);

        do_op("add_lone", 1'b0, 4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
        do_op("div_zero", 1'b1, 4'b0111, 16'h0010, 16'h0000, 16'h0000, 1'b1);
        do_op("mod_zero", 1'b1, 4'b1001, 16'h0010, 16'h0000, 16'h0000, 1'b1);
        do_op("div_3",    1'b1, 4'b0111, 16'h0010, 16'h0003, 16'h0005, 1'b0);
        do_op("mod_3",    1'b0, 4'b1001, 16'h0010, 16'h0003, 16'h0001, 1'b0);
        do_op("illegal",  1'b0, 4'b1111, 16'h1234, 16'h5678, 16'h0000, 1'b1);
        do_op("illeg6",   1'b1, 4'b0110, 16'h1234, 16'h5678, 16'h0000, 1'b1);
        do_op("mul",      1'b0, 4'b0101, 16'h0100, 16'h0100, 16'h0000, 1'b0);
        do_op("mul_lo",   1'b1, 4'b0101, 16'h0123, 16'h0010, 16'h1230, 1'b0);
        do_op("not",      1'b0, 4'b1000, 16'h00FF, 16'hAAAA, 16'hFF00, 1'b0);
        do_op("loadi",    1'b1, 4'b1010, 16'hBEEF, 16'h1111, 16'hBEEF, 1'b0);
        do_op("and",      1'b0, 4'b0010, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0);

        // Backpressure: port 0 holds its response for 5 cycles while port 1 waits.
        req0_valid = 1; req0_op = 4'b0000; req0_a = 16'h0005; req0_b = 16'h0006;
        #1;
        chk("bp_grant0", {14'b0, req1_ready, req0_ready}, 16'h1);
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 1; req1_op = 4'b0100; req1_a = 16'hF0F0; req1_b = 16'h0FF0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            rsp1_ready = k[0];
            #1;
            chk($sformatf("bp%0d_valid", k), {14'b0, rsp1_valid, rsp0_valid}, 16'h1);
            chk($sformatf("bp%0d_result", k), rsp0_result, 16'h000B);
            chk($sformatf("bp%0d_err", k), {15'b0, rsp0_err}, 16'h0);
            chk($sformatf("bp%0d_req1_ready", k), {15'b0, req1_ready}, 16'h0);
            @(negedge clk);
        end
        rsp1_ready = 0;
        rsp0_ready = 1;
        @(negedge clk);
        #1;
        chk("bp_grant1", {14'b0, req1_ready, req0_ready}, 16'h2);
        @(negedge clk);
        req1_valid = 0; rsp0_ready = 0;
        @(negedge clk);
        #1;
        chk("bp_rsp1_valid", {14'b0, rsp1_valid, rsp0_valid}, 16'h2);
        chk("bp_rsp1_result", rsp1_result, 16'hFF00);
        rsp1_ready = 1;
        @(negedge clk);
        clear_inputs();

        // Reset while a response is pending.
        req0_valid = 1; req0_op = 4'b0011; req0_a = 16'h00F0; req0_b = 16'h0F00;
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        #1;
        chk("rstr_valid", {15'b0, rsp0_valid}, 16'h1);
        chk("rstr_result", rsp0_result, 16'h0FF0);
        rst_n = 0;
        #1;
        check_all_zero("rstr_asserted");
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rstr_quiet%0d", k), {13'b0, busy, rsp1_valid, rsp0_valid}, 16'h0);
        end

        // First contended grant after reset goes to port 0.
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("rstr_first_grant", {14'b0, req1_ready, req0_ready}, 16'h1);
        @(negedge clk);
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
